rv32i_fetch: RTL and testbench
==============================

Name: rv32i_fetch

Overview:
Instruction fetch stage for the RV32I core; sits directly upstream of the D/C/W instruction pipeline and drives its fetch-stage instruction input.
Holds the PC and issues in-order word requests to instruction memory through a valid/ready request channel, with credit-limited outstanding requests.
Buffers returned words with their PCs in a small FIFO and presents one instruction per cycle to decode.
Supports a redirect (branch/jump) from the compute stage: the FIFO is flushed and in-flight responses are discarded.

Parameters:
WIDTH, 32, instruction/address width
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, FIFO entries; power of 2, >=2; also the outstanding-request credit limit

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
req_valid  output  1  imem request valid
req_ready  input  1  imem accepts request this cycle
req_addr  output  WIDTH  word-aligned fetch address (= pc)
rsp_valid  input  1  imem returns one word, in request order
rsp_data  input  WIDTH  returned instruction word
redirect_valid  input  1  redirect PC this cycle
redirect_pc  input  WIDTH  redirect target
inst_ready  input  1  decode accepts instruction (0 = stall)
inst_valid  output  1  inst/inst_pc hold a real instruction
inst  output  WIDTH  instruction to pipeline; NOP 32'h0000_0013 when !inst_valid
inst_pc  output  WIDTH  PC of inst; 0 when !inst_valid

Behaviour:
- Reset:
  - pc <= RESET_PC; FIFO empty; outstanding <= 0; discard <= 0.
  - Outputs: req_valid=0, inst_valid=0, inst=NOP, inst_pc=0.
  - Reset mid-operation drops all buffered and in-flight state. The bench must not return stale responses after reset.
- Request:
  - req_valid = !reset && !redirect_valid && (outstanding + fifo_count < DEPTH).
  - req_addr = pc.
  - Fire = req_valid && req_ready: pc <= pc + 4 (mod 2^WIDTH, wraps), outstanding++.
- Response:
  - rsp_valid: outstanding--.
  - If discard > 0: word dropped, discard--.
  - Else: {pc_of_word, rsp_data} pushed to FIFO. The credit rule guarantees space.
  - rsp_valid with outstanding==0 is a protocol error; the word is ignored and the counters are unchanged.
- Response PCs: a separate tag FIFO is not needed. A resp_pc register is loaded with pc on redirect/reset and increments by 4 per accepted (non-discarded) response.
- Output:
  - inst/inst_pc/inst_valid come combinationally from the registered FIFO head.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle leave the count unchanged.
- Latency: request fire at cycle t, rsp_valid at t+k. The word appears on inst at cycle t+k+1.
- Redirect (highest priority, overrides push/pop/request):
  - pc <= {redirect_pc[WIDTH-1:2], 2'b00}; resp_pc <= same; FIFO flushed.
  - discard <= outstanding - rsp_valid (all still-outstanding words are discarded); outstanding <= outstanding - rsp_valid.
  - inst_valid deasserts the following cycle.
  - A redirect during a stall (inst_ready=0) discards the held instruction.
  - Back-to-back redirects: the last one wins; discard is recomputed each time.
- Full FIFO with inst_ready=0: req_valid stays low (no credit); pc holds.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty, discard==0, and a response is accepted, rsp_data/resp_pc drive inst/inst_pc combinationally in the same cycle with inst_valid=1.
  - If inst_ready=1, the word is consumed without a push.
  - If inst_ready=0, it is pushed as normal.
  - Latency drops to t+k.
- Undefined: no bypass; behaviour exactly as above.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN=32
  - RV32I_NOP=32'h0000_0013
  - default RESET_PC
  - ilen_t typedef for 32-bit words
- Sub-module fetch_fifo (DEPTH entries of {pc, inst}):
  - ports: push, pop, flush, count, head outputs
  - flush has priority over push/pop.
- The fetch top holds the pc, outstanding/discard counters, resp_pc and the request/redirect logic.

Test Plan:
- Reset release, imem always ready, 1-cycle response → first req_addr 0x0. inst=NOP until the cycle after the first rsp. Then inst_pc 0x0, 0x4, 0x8… one per cycle.
- inst_ready=0 for 6 cycles → at most DEPTH=2 requests outstanding+buffered. req_valid low, pc frozen. On release, inst_pc resumes in order with no gap or duplicate.
- redirect_valid with redirect_pc=0x103 and 2 requests outstanding → next req_addr 0x100. Both stale responses are dropped. The first inst_valid has inst_pc=0x100.
- redirect coincident with rsp_valid and a FIFO pop → the rsp is discarded, discard=outstanding-1, and nothing pops to decode after the redirect.
- req_ready toggling randomly with a 3-cycle response delay, checked against a reference PC model → in-order inst stream with no loss. pc wraps 0xFFFF_FFFC→0x0.
- FETCH_BYPASS_EN defined, empty FIFO, rsp at cycle t with inst_ready=1 → inst valid at cycle t and fifo_count stays 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and word type for the front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] ilen_t;

    // addi x0, x0, 0 -- what decode sees whenever fetch has nothing real to offer
    localparam ilen_t RV32I_NOP        = 32'h0000_0013;
    localparam ilen_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/rv32i_fetch_if.sv
// rv32i_fetch_if: imem request/response, redirect and decode-side signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: req_ready throttles requests, inst_ready stalls the instruction output.
interface rv32i_fetch_if
    import rv32i_pkg::*;
#(
    parameter int WIDTH = XLEN
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             inst_ready;
    logic             inst_valid;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] inst_pc;

    // fetch stage side
    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc,
        input  req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
    );

    // imem / decode / compute side
    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc,
        output req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/rv32i_fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of {pc, inst} pairs with a registered head.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; push on full without pop and pop on empty are ignored; flush beats push/pop.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_pc_i,
    input  logic [WIDTH-1:0] push_inst_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CW-1:0]    count_o,
    output logic             head_vld_o,
    output logic [WIDTH-1:0] head_pc_o,
    output logic [WIDTH-1:0] head_inst_o
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [WIDTH-1:0] inst_mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0) && !flush_i;
    assign do_push = push_i && ((cnt_q != DEPTH_C) || do_pop) && !flush_i;
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

    // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // entry storage needs no reset: occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem_q[wr_q]   <= push_pc_i;
            inst_mem_q[wr_q] <= push_inst_i;
        end
    end

    assign count_o     = cnt_q;
    assign head_vld_o  = (cnt_q != '0);
    assign head_pc_o   = pc_mem_q[rd_q];
    assign head_inst_o = inst_mem_q[rd_q];
endmodule

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: holds the PC, issues in-order imem word requests and feeds decode one instruction per cycle.
// Latency: request at t, response at t+k, instruction on inst at t+k+1 (t+k when FETCH_BYPASS_EN is defined).
// Backpressure: outstanding + buffered words capped at DEPTH; inst_ready=0 starves requests once credit is spent.
// Build option: `define FETCH_BYPASS_EN forwards an accepted response straight to decode while the FIFO is empty.
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int               DEPTH    = 2
) (
    input logic           clk,
    input logic           reset,
    rv32i_fetch_if.master bus
);
    localparam int               CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]      DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]    out_q, out_d;
    logic [CW-1:0]    disc_q, disc_d;
    logic [CW-1:0]    fifo_cnt;
    logic [CW:0]      in_use;
    logic [WIDTH-1:0] redir_tgt;
    logic [WIDTH-1:0] head_pc, head_inst;
    logic             head_vld, head_live;
    logic             fire, rsp_ok, accept, push, pop, bypass;

    assign redir_tgt = {bus.redirect_pc[WIDTH-1:2], 2'b00};
    assign in_use    = {1'b0, out_q} + {1'b0, fifo_cnt};

    // a new request only when every possible returning word already has a FIFO slot reserved
    assign bus.req_valid = !reset && !bus.redirect_valid && (in_use < DEPTH_C);
    assign bus.req_addr  = pc_q;
    assign fire          = bus.req_valid && bus.req_ready;

    // a response with nothing outstanding is a protocol error and is ignored outright
    assign rsp_ok = bus.rsp_valid && (out_q != '0) && !reset;
    assign accept = rsp_ok && (disc_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && !bus.redirect_valid && (fifo_cnt == '0);
`else
    assign bypass = 1'b0;
`endif

    assign head_live = head_vld && !reset;
    assign push      = accept && !bus.redirect_valid && !(bypass && bus.inst_ready);
    assign pop       = head_live && bus.inst_ready && !bus.redirect_valid;

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_pc_i   (resp_pc_q),
        .push_inst_i (bus.rsp_data),
        .pop_i       (pop),
        .flush_i     (bus.redirect_valid),
        .count_o     (fifo_cnt),
        .head_vld_o  (head_vld),
        .head_pc_o   (head_pc),
        .head_inst_o (head_inst)
    );

    // next state for pc, response pc and the two counters; redirect overrides everything
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q + CW'(fire) - CW'(rsp_ok);
        disc_d    = disc_q - CW'(rsp_ok && (disc_q != '0));
        if (fire)   pc_d      = pc_q + PC_STEP;
        if (accept) resp_pc_d = resp_pc_q + PC_STEP;
        if (bus.redirect_valid) begin
            pc_d      = redir_tgt;
            resp_pc_d = redir_tgt;
            out_d     = out_q - CW'(rsp_ok);
            disc_d    = out_q - CW'(rsp_ok);
        end
    end

    // fetch state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
        end
    end

    // decode-facing outputs: FIFO head first, then a bypassed response, else a NOP bubble
    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst       = WIDTH'(RV32I_NOP);
        bus.inst_pc    = '0;
        if (head_live) begin
            bus.inst_valid = 1'b1;
            bus.inst       = head_inst;
            bus.inst_pc    = head_pc;
        end else if (bypass) begin
            bus.inst_valid = 1'b1;
            bus.inst       = bus.rsp_data;
            bus.inst_pc    = resp_pc_q;
        end
    end
endmodule

// File: tb/tb_rv32i_fetch.sv
// tb_rv32i_fetch: randomized scoreboard bench for the fetch stage with a delayed in-order imem model.
// Latency: imem answers k cycles after a request fires.
// Backpressure: req_ready and inst_ready driven from directed phases and $urandom.
module tb_rv32i_fetch;
    localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } imem_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32i_fetch_if #(.WIDTH(32)) bus ();

    rv32i_fetch #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          k_lat    = 1;
    int          consumed = 0;
    int          lat_fire = -1;
    int          lat_k    = 1;
    bit          lat_on   = 1'b0;
    bit          prev_redir = 1'b0;
    bit          wrap_seen  = 1'b0;
    logic [31:0] last_pc  = 32'h0;
    logic [31:0] model_pc = 32'h0;
    imem_t       imem_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // imem: answers each fired request in order once its due cycle arrives
    initial begin
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_q.size() > 0 && imem_q[0].due == cyc) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = mem_word(imem_q[0].addr);
                void'(imem_q.pop_front());
            end else begin
                bus.rsp_valid = 1'b0;
                bus.rsp_data  = $urandom;
            end
        end
    end

    // monitor: reference PC stream, credit bound and in-order delivery
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk(!bus.req_valid && !bus.inst_valid, "reset_valids", {30'b0, bus.req_valid, bus.inst_valid}, 32'h0);
                chk(bus.inst == NOP_W && bus.inst_pc == 32'h0, "reset_inst_nop", bus.inst, NOP_W);
                imem_q.delete();
                exp_q.delete();
                model_pc   = 32'h0;
                prev_redir = 1'b0;
                lat_on     = 1'b1;
                lat_fire   = -1;
            end else begin
                if (prev_redir)
                    chk(!bus.inst_valid, "inst_valid_after_redirect", 32'(bus.inst_valid), 32'h0);
                if (bus.redirect_valid)
                    chk(!bus.req_valid, "req_valid_during_redirect", 32'(bus.req_valid), 32'h0);
                if (bus.req_valid)
                    chk(bus.req_addr == model_pc, "req_addr", bus.req_addr, model_pc);
                if (!bus.inst_valid) begin
                    chk(bus.inst == NOP_W && bus.inst_pc == 32'h0, "idle_nop", bus.inst, NOP_W);
                end else if (lat_on) begin
                    chk(lat_fire >= 0 && cyc == lat_fire + lat_k + 1 - BYP, "first_latency",
                        32'(cyc), 32'(lat_fire + lat_k + 1 - BYP));
                    lat_on = 1'b0;
                end
                if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_inst", bus.inst_pc, 32'h0);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        chk(bus.inst_pc == e, "inst_pc", bus.inst_pc, e);
                        chk(bus.inst == mem_word(e), "inst_data", bus.inst, mem_word(e));
                        if (e == 32'h0 && last_pc == 32'hFFFF_FFFC && consumed > 0) wrap_seen = 1'b1;
                        last_pc = e;
                        consumed++;
                    end
                end
                if (bus.req_valid && bus.req_ready) begin
                    int due;
                    due = cyc + k_lat;
                    if (imem_q.size() > 0 && due <= imem_q[$].due) due = imem_q[$].due + 1;
                    imem_q.push_back('{bus.req_addr, due});
                    exp_q.push_back(bus.req_addr);
                    model_pc = model_pc + 32'h4;
                    if (lat_on && lat_fire < 0) begin
                        lat_fire = cyc;
                        lat_k    = k_lat;
                    end
                    chk(imem_q.size() <= DEPTH && exp_q.size() <= DEPTH, "credit_limit",
                        32'(imem_q.size() + exp_q.size()), 32'(DEPTH));
                end
                if (bus.redirect_valid) begin
                    exp_q.delete();
                    model_pc = {bus.redirect_pc[31:2], 2'b00};
                    lat_on   = 1'b0;
                end
                prev_redir = bus.redirect_valid;
            end
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // stimulus
    initial begin
        bit found;
        reset              = 1'b1;
        bus.req_ready      = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (3) next_cycle();

        // steady streaming, 1-cycle imem
        reset          = 1'b0;
        bus.req_ready  = 1'b1;
        bus.inst_ready = 1'b1;
        k_lat          = 1;
        repeat (12) next_cycle();

        // decode stall: credit runs out, requests stop
        bus.inst_ready = 1'b0;
        repeat (6) next_cycle();
        #2;
        chk(!bus.req_valid, "stall_req_valid", 32'(bus.req_valid), 32'h0);
        bus.inst_ready = 1'b1;
        repeat (8) next_cycle();

        // redirect with requests outstanding on a slower imem
        k_lat = 3;
        repeat (10) next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        next_cycle();
        bus.redirect_valid = 1'b0;
        repeat (12) next_cycle();

        // back-to-back redirects: last one wins
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        next_cycle();
        bus.redirect_pc    = 32'h0000_0305;
        next_cycle();
        bus.redirect_valid = 1'b0;
        repeat (12) next_cycle();

        // redirect coinciding with a response and a decode pop
        k_lat = 1;
        repeat (8) next_cycle();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            if (bus.rsp_valid && bus.inst_valid) found = 1'b1;
        end
        chk(found, "coincide_setup", 32'(found), 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0400;
        next_cycle();
        bus.redirect_valid = 1'b0;
        repeat (10) next_cycle();

        // PC wrap under random backpressure
        k_lat = 3;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF0;
        next_cycle();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.req_ready  = ($urandom_range(0, 9) < 7);
            bus.inst_ready = ($urandom_range(0, 9) < 6);
            next_cycle();
        end
        chk(wrap_seen, "pc_wrap", 32'(wrap_seen), 32'h1);

        // random traffic with random redirects and one mid-run reset
        for (int i = 0; i < 500; i++) begin
            bus.req_ready  = ($urandom_range(0, 9) < 7);
            bus.inst_ready = ($urandom_range(0, 9) < 6);
            if (i == 250 || i == 251) begin
                reset              = 1'b1;
                bus.redirect_valid = 1'b0;
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 39) == 0) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = ($urandom_range(0, 3) == 0) ?
                                         32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : 32'($urandom);
                end else begin
                    bus.redirect_valid = 1'b0;
                end
            end
            next_cycle();
        end

        // drain: no new requests, everything fired must come out
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.req_ready      = 1'b0;
        bus.inst_ready     = 1'b1;
        repeat (12) next_cycle();
        chk(exp_q.size() == 0, "drain_no_loss", 32'(exp_q.size()), 32'h0);
        chk(consumed > 100, "progress", 32'(consumed), 32'd101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
